// File: rtl/note_countdown.sv
// Per-note response timer: loads a countdown on start, steps it down once per step
// period, and ends in a hit or a miss. The optional pause input exists only when
// NOTE_COUNTDOWN_PAUSE_EN is defined.
module note_countdown #(
    parameter int TICKS_PER_STEP = 25_000_000,
    parameter int START_COUNT    = 4,
    parameter int HOLD_STEPS     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       correct_note,
    input  logic       clear,
`ifdef NOTE_COUNTDOWN_PAUSE_EN
    input  logic       pause,
`endif
    output logic [2:0] countdown,
    output logic       correct_out,
    output logic       busy,
    output logic       hit,
    output logic       miss,
    output logic [1:0] last_result,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam int TW = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_STEP - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [2:0]    START_VAL = 3'(START_COUNT);

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [HW-1:0] hold_cnt;
    logic          step;
    logic          frozen;

`ifdef NOTE_COUNTDOWN_PAUSE_EN
    assign frozen = pause;
`else
    assign frozen = 1'b0;
`endif

    assign step      = (tick_cnt == TICK_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            hold_cnt    <= '0;
            countdown   <= 3'd0;
            correct_out <= 1'b0;
            busy        <= 1'b0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            last_result <= 2'b00;
            hit_count   <= 8'd0;
            miss_count  <= 8'd0;
        end else begin
            hit         <= 1'b0;
            miss        <= 1'b0;
            correct_out <= correct_note;
            case (state)
                IDLE: begin
                    tick_cnt  <= '0;
                    hold_cnt  <= '0;
                    countdown <= 3'd0;
                    busy      <= 1'b0;
                    if (start) begin
                        state       <= COUNT;
                        countdown   <= START_VAL;
                        busy        <= 1'b1;
                        last_result <= 2'b00;
                    end
                end
                COUNT: begin
                    if (!frozen) begin
                        tick_cnt <= step ? '0 : tick_cnt + 1'b1;
                        // A key press wins over a coincident final step.
                        if (correct_note) begin
                            state       <= RESULT;
                            hit         <= 1'b1;
                            last_result <= 2'b01;
                            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
                            countdown   <= 3'd0;
                            tick_cnt    <= '0;
                            hold_cnt    <= '0;
                        end else if (step && countdown == 3'd1) begin
                            state       <= RESULT;
                            miss        <= 1'b1;
                            last_result <= 2'b10;
                            if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
                            countdown   <= 3'd0;
                            tick_cnt    <= '0;
                            hold_cnt    <= '0;
                        end else if (step) begin
                            countdown <= countdown - 3'd1;
                        end
                    end
                end
                RESULT: begin
                    if (!frozen) begin
                        tick_cnt <= step ? '0 : tick_cnt + 1'b1;
                        if (step) begin
                            if (hold_cnt == HOLD_LAST) begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Clear overrides any increment made above in the same cycle.
            if (clear) begin
                hit_count  <= 8'd0;
                miss_count <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_note_countdown.sv
// Bench for note_countdown: directed steps plus random traffic, every cycle checked
// against an elapsed-time model of the response window.
module tb_note_countdown;

    localparam int T     = 4;
    localparam int START = 4;
    localparam int HOLD  = 2;

    logic       clk = 1'b0;
    logic       reset, start, correct_note, clear, pause;
    logic [2:0] countdown;
    logic       correct_out, busy, hit, miss;
    logic [1:0] last_result, state_dbg;
    logic [7:0] hit_count, miss_count;

    int nvec = 0;
    int nerr = 0;

    // Model: phase 0 idle, 1 counting, 2 holding; elapsed cycles within the phase.
    int   m_phase, m_elapsed, m_hits, m_misses;
    bit   m_hit, m_miss, m_corr;
    logic [1:0] m_last;

    note_countdown #(
        .TICKS_PER_STEP(T),
        .START_COUNT(START),
        .HOLD_STEPS(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .correct_note(correct_note),
        .clear(clear),
`ifdef NOTE_COUNTDOWN_PAUSE_EN
        .pause(pause),
`endif
        .countdown(countdown),
        .correct_out(correct_out),
        .busy(busy),
        .hit(hit),
        .miss(miss),
        .last_result(last_result),
        .hit_count(hit_count),
        .miss_count(miss_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit paused;
`ifdef NOTE_COUNTDOWN_PAUSE_EN
        paused = pause;
`else
        paused = 1'b0;
`endif
        m_hit  = 1'b0;
        m_miss = 1'b0;
        if (reset) begin
            m_phase = 0; m_elapsed = 0; m_hits = 0; m_misses = 0;
            m_corr = 1'b0; m_last = 2'b00;
        end else begin
            m_corr = correct_note;
            if (m_phase == 0) begin
                if (start) begin
                    m_phase = 1; m_elapsed = 0; m_last = 2'b00;
                end
            end else if (m_phase == 1) begin
                if (!paused) begin
                    if (correct_note) begin
                        m_hit = 1'b1; m_last = 2'b01;
                        m_hits = (m_hits < 255) ? m_hits + 1 : 255;
                        m_phase = 2; m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == START * T) begin
                            m_miss = 1'b1; m_last = 2'b10;
                            m_misses = (m_misses < 255) ? m_misses + 1 : 255;
                            m_phase = 2; m_elapsed = 0;
                        end
                    end
                end
            end else begin
                if (!paused) begin
                    m_elapsed++;
                    if (m_elapsed == HOLD * T) begin
                        m_phase = 0; m_elapsed = 0;
                    end
                end
            end
            if (clear) begin
                m_hits = 0; m_misses = 0;
            end
        end
    endtask

    task automatic check_all();
        int exp_cd;
        exp_cd = (m_phase == 1) ? START - m_elapsed / T : 0;
        check("countdown", 8'(countdown), 8'(exp_cd));
        check("correct_out", 8'(correct_out), 8'(m_corr));
        check("busy", 8'(busy), 8'(m_phase != 0));
        check("hit", 8'(hit), 8'(m_hit));
        check("miss", 8'(miss), 8'(m_miss));
        check("last_result", 8'(last_result), 8'(m_last));
        check("hit_count", hit_count, 8'(m_hits));
        check("miss_count", miss_count, 8'(m_misses));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; correct_note = 1'b0; clear = 1'b0; pause = 1'b0;
        m_phase = 0; m_elapsed = 0; m_hits = 0; m_misses = 0;
        m_hit = 1'b0; m_miss = 1'b0; m_corr = 1'b0; m_last = 2'b00;
        @(negedge clk);
        run(3);
        check("reset_countdown", 8'(countdown), 8'd0);
        reset = 1'b0;
        run(2);

        // Full window with no key: expiry, then hold.
        pulse_start();
        check("first_countdown", 8'(countdown), 8'd4);
        run(16);
        check("miss_pulse", 8'(miss), 8'd1);
        check("miss_count_one", miss_count, 8'd1);
        run(10);

        // Key pressed while countdown is 3.
        pulse_start();
        run(5);
        correct_note = 1'b1;
        cycle();
        correct_note = 1'b0;
        check("hit_at_3", 8'(hit), 8'd1);
        check("last_hit", 8'(last_result), 8'd1);
        run(10);

        // Key coincident with the final step.
        pulse_start();
        run(15);
        correct_note = 1'b1;
        cycle();
        correct_note = 1'b0;
        check("final_step_hit", 8'(hit), 8'd1);
        check("final_step_no_miss", 8'(miss), 8'd0);
        run(10);

        // Reset mid-window at countdown 2.
        pulse_start();
        run(9);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("abort_busy", 8'(busy), 8'd0);
        check("abort_hits", hit_count, 8'd0);
        run(2);

        // Restarts during COUNT and RESULT are ignored.
        pulse_start();
        run(3);
        pulse_start();
        run(6);
        pulse_start();
        run(8);
        pulse_start();
        run(12);

        // Saturate the hit tally, then clear together with a hit.
        for (int w = 0; w < 256; w++) begin
            pulse_start();
            correct_note = 1'b1;
            cycle();
            correct_note = 1'b0;
            run(8);
        end
        check("hit_saturated", hit_count, 8'd255);
        pulse_start();
        correct_note = 1'b1;
        clear = 1'b1;
        cycle();
        correct_note = 1'b0;
        clear = 1'b0;
        check("clear_beats_hit", hit_count, 8'd0);
        run(9);

`ifdef NOTE_COUNTDOWN_PAUSE_EN
        // Pause at countdown 3 with the key held: no hit, value frozen.
        pulse_start();
        run(5);
        pause = 1'b1;
        correct_note = 1'b1;
        run(10);
        check("paused_countdown", 8'(countdown), 8'd3);
        pause = 1'b0;
        correct_note = 1'b0;
        run(30);
`endif

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            start        = ($urandom_range(0, 7) == 0);
            correct_note = ($urandom_range(0, 11) == 0);
            clear        = ($urandom_range(0, 99) == 0);
            reset        = ($urandom_range(0, 299) == 0);
`ifdef NOTE_COUNTDOWN_PAUSE_EN
            pause        = ($urandom_range(0, 9) == 0);
`endif
            cycle();
        end
        reset = 1'b0; start = 1'b0; correct_note = 1'b0; clear = 1'b0; pause = 1'b0;
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/note_countdown.md
Name: note_countdown

Overview:
- Per-note response timer for the piano practice mode.
- Sits directly upstream of the interval LED bar stage: drives its 3-bit countdown input (4..1 lights 4..1 LEDs, 0 blanks them) and its correct_note input.
- Started once per prompted note; steps down once per step period; ends in a hit (correct key before expiry) or a miss (expiry).
- Keeps saturating hit/miss tallies for the score display.

Parameters:
- TICKS_PER_STEP, 25_000_000: clk cycles per countdown step (0.25 s at 100 MHz); must be >= 2.
- START_COUNT, 4: countdown load value on start; legal range 1..7.
- HOLD_STEPS, 2: step periods the RESULT state is held before returning to IDLE; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request: a new note has been prompted
- correct_note  input  1  level from key matcher: expected key is pressed
- clear  input  1  synchronous clear of hit_count and miss_count
- countdown  output  3  remaining steps; 0 when not counting
- correct_out  output  1  registered copy of correct_note, for the LED stage
- busy  output  1  high in COUNT and RESULT
- hit  output  1  one-cycle pulse when a window ends with a correct key
- miss  output  1  one-cycle pulse when a window expires
- last_result  output  2  00 none, 01 hit, 10 miss; held until the next accepted start
- hit_count  output  8  saturating hit tally
- miss_count  output  8  saturating miss tally

Behaviour:
- All outputs are registered.
- Reset (sync, active-high, valid at any time including mid-window):
  - state IDLE; prescaler 0; all outputs 0.
  - No hit/miss pulse is generated for an aborted window.
- Prescaler: tick_cnt counts 0..TICKS_PER_STEP-1 while in COUNT or RESULT. step = (tick_cnt == TICKS_PER_STEP-1), after which it wraps to 0. Held at 0 in IDLE.
- IDLE:
  - countdown=0, busy=0.
  - start=1: go to COUNT, countdown<=START_COUNT, tick_cnt<=0, last_result<=00. Visible the cycle after start is sampled.
- COUNT, priority order per cycle:
  1. correct_note=1: go to RESULT; hit=1 for one cycle; last_result<=01; hit_count+1 saturating at 255; countdown<=0; tick_cnt<=0.
  2. Else if step and countdown==1: go to RESULT; miss=1 for one cycle; last_result<=10; miss_count+1 saturating at 255; countdown<=0; tick_cnt<=0.
  3. Else if step: countdown<=countdown-1.
  - correct_note beats a coincident final step, so it counts as a hit.
  - Each countdown value is held exactly TICKS_PER_STEP cycles.
  - start while in COUNT is ignored.
- RESULT:
  - countdown=0, busy=1.
  - Counts HOLD_STEPS steps, then returns to IDLE.
  - start and correct_note are ignored.
  - The start that is accepted next must occur in IDLE.
- correct_out <= correct_note every cycle, in all states; it is 0 only under reset.
- clear=1: hit_count and miss_count <= 0.
  - clear beats a same-cycle increment; the result is 0.
  - clear does not affect state, countdown or last_result.
- hit and miss are never high in the same cycle.
- Latency, start to miss with no key: countdown goes high 1 cycle after start; miss pulses START_COUNT*TICKS_PER_STEP cycles after that.

Optional Feature:
- Macro NOTE_COUNTDOWN_PAUSE_EN.
- Defined:
  - adds input port pause (1 bit).
  - While pause=1 in COUNT or RESULT: tick_cnt, countdown and the hold counter freeze.
  - correct_note is ignored during pause (no hit); start is ignored; clear still acts.
  - Counting resumes from the frozen values the cycle after pause falls.
  - In IDLE, pause has no effect.
- Undefined: no pause port; behaviour exactly as above.

Test Plan (sim parameters TICKS_PER_STEP=4, START_COUNT=4, HOLD_STEPS=2):
- Reset, then start pulse with no key -> countdown 4,3,2,1, each held 4 cycles; miss=1 for one cycle 16 cycles after countdown first reads 4; last_result=10; miss_count=1; busy falls 8 cycles after the miss pulse.
- Start, then correct_note=1 while countdown=3 -> hit pulse on the next cycle; countdown=0; last_result=01; hit_count=1; no miss pulse.
- correct_note asserted in the same cycle as the final step (countdown=1, tick_cnt=3) -> hit=1, miss stays 0; hit_count increments.
- Reset asserted mid-COUNT (countdown=2) -> next cycle: countdown=0, busy=0, counts 0, no pulses. Also: start during COUNT and during RESULT -> ignored; countdown sequence unchanged.
- 256 consecutive hit windows -> hit_count saturates at 255; then clear together with a hit -> hit_count=0.
- With NOTE_COUNTDOWN_PAUSE_EN: pause held 10 cycles at countdown=3 -> countdown stays 3 and correct_note is ignored; after release, 3 completes its remaining ticks before stepping to 2.
